// File: rtl/uart_pkg.sv
// Shared UART definitions: framer states and parity modes, used by the TX block
// and the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        MARK,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU-side write port of the UART transmitter plus its status flags.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 8
);
    // Handshake: tx_write is the valid, tx_rdy the ready; one entry transfers on every
    // clk edge where both are high. tx_write while !tx_rdy loses the entry and sets tx_ovf.
    logic                   tx_write;
    logic [DATA_BITS-1:0]   tx_data;
    logic                   tx_rdy;
    logic                   tx_empty;
    logic                   tx_idle;
    logic [$clog2(DEPTH):0] tx_level;
    logic                   tx_ovf;

    modport master (
        output tx_write, tx_data,
        input  tx_rdy, tx_empty, tx_idle, tx_level, tx_ovf
    );

    modport slave (
        input  tx_write, tx_data,
        output tx_rdy, tx_empty, tx_idle, tx_level, tx_ovf
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count and sticky overflow flag; head entry is
// visible on dout whenever the FIFO is not empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LEVEL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push && full) begin
                ovf <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter: TX FIFO feeding a framer with runtime parity and
// stop-bit selection, paced by an external oversampled baud tick.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int DEPTH      = 8,
    parameter int OVERSAMPLE = 16,
    parameter int RESET_MARK = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           baud_tick,
    input  logic           cfg_par_en,
    input  logic           cfg_par_odd,
    input  logic           cfg_stop2,
    uart_tx_fifo_if.slave  bus,
    output logic           tx,
    output tx_state_e      dbg_state
);
    localparam int TW   = $clog2(OVERSAMPLE);
    localparam int BMAX = (RESET_MARK > DATA_BITS) ? RESET_MARK : DATA_BITS;
    localparam int BW   = $clog2(BMAX);

    tx_state_e            state, state_n;
    logic [TW-1:0]        tick_cnt, tick_cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_bit, par_bit_n;
    logic                 par_en_q, par_en_n;
    logic                 stop2_q, stop2_n;
    logic                 tx_q, tx_n;
    logic                 launch;
    logic                 tick_last;
    parity_e              par_mode;

    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.tx_write),
        .pop   (launch),
        .din   (bus.tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (bus.tx_level),
        .ovf   (bus.tx_ovf)
    );

    assign bus.tx_rdy   = !fifo_full;
    assign bus.tx_empty = fifo_empty;
    assign bus.tx_idle  = (state == IDLE) && fifo_empty;
    assign tx           = tx_q;
    assign dbg_state    = state;
    assign tick_last    = (tick_cnt == TW'(OVERSAMPLE - 1));
    assign par_mode     = !cfg_par_en ? PAR_NONE : (cfg_par_odd ? PAR_ODD : PAR_EVEN);

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        par_bit_n  = par_bit;
        par_en_n   = par_en_q;
        stop2_n    = stop2_q;
        tx_n       = tx_q;
        launch     = 1'b0;
        if (baud_tick) begin
            tick_cnt_n = tick_last ? '0 : tick_cnt + 1'b1;
            unique case (state)
                MARK: begin
                    if (tick_last) begin
                        if (bit_cnt == BW'(RESET_MARK - 1)) begin
                            state_n   = IDLE;
                            bit_cnt_n = '0;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end
                end
                IDLE: begin
                    tick_cnt_n = '0;
                    launch     = !fifo_empty;
                end
                START: begin
                    if (tick_last) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                        tx_n      = shift[0];
                    end
                end
                DATA: begin
                    if (tick_last) begin
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            bit_cnt_n = '0;
                            state_n   = par_en_q ? PARITY : STOP;
                            tx_n      = par_en_q ? par_bit : 1'b1;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                            shift_n   = shift >> 1;
                            tx_n      = shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick_last) begin
                        state_n   = STOP;
                        bit_cnt_n = '0;
                        tx_n      = 1'b1;
                    end
                end
                STOP: begin
                    if (tick_last) begin
                        if (stop2_q && (bit_cnt == '0)) begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end else if (!fifo_empty) begin
                            // Next frame starts on this very tick: no idle bit between frames.
                            launch = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                default: begin
                    state_n = MARK;
                end
            endcase
            if (launch) begin
                state_n    = START;
                tick_cnt_n = '0;
                bit_cnt_n  = '0;
                shift_n    = fifo_dout;
                par_bit_n  = (^fifo_dout) ^ (par_mode == PAR_ODD);
                par_en_n   = (par_mode != PAR_NONE);
                stop2_n    = cfg_stop2;
                tx_n       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MARK;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            par_bit  <= par_bit_n;
            par_en_q <= par_en_n;
            stop2_q  <= stop2_n;
            tx_q     <= tx_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8-bit/x16 instance and a 5-bit/x4 instance
// sharing clock, reset, baud tick and configuration.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n = 1'b1;
    logic      baud_tick = 1'b0;
    logic      cfg_par_en = 1'b0;
    logic      cfg_par_odd = 1'b0;
    logic      cfg_stop2 = 1'b0;
    logic      tx_a, tx_b;
    tx_state_e state_a, state_b;

    int tests = 0;
    int fails = 0;
    int tick_no = 0;
    int clk_div = 0;
    logic [7:0] exp_q[$];

    uart_tx_fifo_if #(.DATA_BITS(8), .DEPTH(8)) bus_a ();
    uart_tx_fifo_if #(.DATA_BITS(5), .DEPTH(8)) bus_b ();

    uart_tx_fifo #(.DATA_BITS(8), .DEPTH(8), .OVERSAMPLE(16), .RESET_MARK(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2),
        .bus(bus_a.slave), .tx(tx_a), .dbg_state(state_a)
    );

    uart_tx_fifo #(.DATA_BITS(5), .DEPTH(8), .OVERSAMPLE(4), .RESET_MARK(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2),
        .bus(bus_b.slave), .tx(tx_b), .dbg_state(state_b)
    );

    // Clock, baud tick (one clk in four) and tick counter.
    always #5 clk = ~clk;

    always @(negedge clk) begin
        clk_div = (clk_div + 1) % 4;
        baud_tick = (clk_div == 0);
    end

    always @(posedge clk) begin
        if (baud_tick) tick_no <= tick_no + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Driver tasks. All leave time at 1ns after a rising clk edge.
    task automatic tick_wait(input int n);
        repeat (n) begin
            do @(posedge clk); while (baud_tick !== 1'b1);
        end
        #1;
    endtask

    function automatic logic cur_tx(input bit b);
        return b ? tx_b : tx_a;
    endfunction

    task automatic wait_fall(input bit b, input int limit, output int n);
        n = 0;
        while (cur_tx(b) !== 1'b0 && n < limit) begin
            tick_wait(1);
            n++;
        end
    endtask

    task automatic capture(input bit b, input int os, input int nbits, output logic [15:0] bits);
        bits = '0;
        tick_wait(os / 2);
        for (int i = 0; i < nbits; i++) begin
            bits[i] = cur_tx(b);
            if (i < nbits - 1) tick_wait(os);
        end
    endtask

    task automatic write_a(input logic [7:0] d);
        bus_a.tx_write = 1'b1;
        bus_a.tx_data  = d;
        @(posedge clk);
        #1;
        bus_a.tx_write = 1'b0;
    endtask

    task automatic write_b(input logic [4:0] d);
        bus_b.tx_write = 1'b1;
        bus_b.tx_data  = d;
        @(posedge clk);
        #1;
        bus_b.tx_write = 1'b0;
    endtask

    task automatic do_reset();
        bus_a.tx_write = 1'b0;
        bus_b.tx_write = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        tick_wait(1);
        rst_n = 1'b1;
    endtask

    // Scenario tasks.
    task automatic test_reset();
        logic [15:0] bits;
        int n;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (tx_a !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx_a); end
        tests++; if (bus_a.tx_level !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", bus_a.tx_level); end
        tests++; if (bus_a.tx_rdy !== 1'b1 || bus_a.tx_empty !== 1'b1) begin fails++; $display("FAIL reset_rdy_empty: got %b%b want 11", bus_a.tx_rdy, bus_a.tx_empty); end
        tests++; if (bus_a.tx_idle !== 1'b0 || bus_a.tx_ovf !== 1'b0) begin fails++; $display("FAIL reset_idle_ovf: got %b%b want 00", bus_a.tx_idle, bus_a.tx_ovf); end
        tests++; if (state_a !== MARK || state_b !== MARK) begin fails++; $display("FAIL reset_state: got %0d/%0d want MARK", state_a, state_b); end
        tick_wait(1);
        rst_n = 1'b1;
        write_a(8'h55);
        wait_fall(1'b0, 200, n);
        tests++; if (n != 129) begin fails++; $display("FAIL reset_mark_len: start after %0d ticks want 129", n); end
        capture(1'b0, 16, 10, bits);
        tests++; if (bits !== 16'h02AA) begin fails++; $display("FAIL frame_55: got %h want 02aa", bits); end
        tick_wait(7);
        tests++; if (bus_a.tx_idle !== 1'b0) begin fails++; $display("FAIL idle_in_stop: got %b want 0", bus_a.tx_idle); end
        tick_wait(1);
        tests++; if (bus_a.tx_idle !== 1'b1 || tx_a !== 1'b1) begin fails++; $display("FAIL idle_after_stop: got idle=%b tx=%b want 1 1", bus_a.tx_idle, tx_a); end
    endtask

    task automatic test_parity_stop();
        logic [15:0] bits;
        int n;
        cfg_par_en = 1'b1; cfg_par_odd = 1'b0; cfg_stop2 = 1'b1;
        write_a(8'h07);
        wait_fall(1'b0, 4, n);
        tests++; if (n != 1) begin fails++; $display("FAIL latency_even: start after %0d ticks want 1", n); end
        capture(1'b0, 16, 12, bits);
        tests++; if (bits !== 16'h0E0E) begin fails++; $display("FAIL frame_07_even: got %h want 0e0e", bits); end
        tick_wait(7);
        tests++; if (bus_a.tx_idle !== 1'b0) begin fails++; $display("FAIL len_even_191: idle=%b want 0", bus_a.tx_idle); end
        tick_wait(1);
        tests++; if (bus_a.tx_idle !== 1'b1) begin fails++; $display("FAIL len_even_192: idle=%b want 1", bus_a.tx_idle); end
        cfg_par_odd = 1'b1;
        write_a(8'h07);
        wait_fall(1'b0, 4, n);
        tests++; if (n != 1) begin fails++; $display("FAIL latency_odd: start after %0d ticks want 1", n); end
        // Config changed mid-frame must not touch the frame in flight.
        cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
        capture(1'b0, 16, 12, bits);
        tests++; if (bits !== 16'h0C0E) begin fails++; $display("FAIL frame_07_odd: got %h want 0c0e", bits); end
        tick_wait(7);
        tests++; if (bus_a.tx_idle !== 1'b0) begin fails++; $display("FAIL len_odd_191: idle=%b want 0", bus_a.tx_idle); end
        tick_wait(1);
        tests++; if (bus_a.tx_idle !== 1'b1) begin fails++; $display("FAIL len_odd_192: idle=%b want 1", bus_a.tx_idle); end
        cfg_par_en = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic [15:0] bits;
        logic [7:0]  exp;
        int n;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            write_a(8'(i));
            exp_q.push_back(8'(i));
        end
        tests++; if (bus_a.tx_rdy !== 1'b0 || bus_a.tx_level !== 4'd8) begin fails++; $display("FAIL full_flags: rdy=%b level=%0d want 0 8", bus_a.tx_rdy, bus_a.tx_level); end
        tests++; if (bus_a.tx_ovf !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b want 0", bus_a.tx_ovf); end
        write_a(8'h09);
        tests++; if (bus_a.tx_ovf !== 1'b1 || bus_a.tx_level !== 4'd8) begin fails++; $display("FAIL full_drop: ovf=%b level=%0d want 1 8", bus_a.tx_ovf, bus_a.tx_level); end
        tests++; if (state_a !== MARK) begin fails++; $display("FAIL full_in_mark: state=%0d want MARK", state_a); end
        for (int k = 0; k < 8; k++) begin
            wait_fall(1'b0, 200, n);
            if (k > 0) begin
                tests++; if (n != 0) begin fails++; $display("FAIL b2b_gap_%0d: gap %0d ticks want 0", k, n); end
            end
            capture(1'b0, 16, 10, bits);
            exp = exp_q.pop_front();
            tests++; if (bits !== {6'b0, 1'b1, exp, 1'b0}) begin fails++; $display("FAIL b2b_frame_%0d: got %h want byte %h", k, bits, exp); end
            tick_wait(8);
        end
        tests++; if (bus_a.tx_idle !== 1'b1 || bus_a.tx_level !== 4'd0) begin fails++; $display("FAIL drain_idle: idle=%b level=%0d want 1 0", bus_a.tx_idle, bus_a.tx_level); end
    endtask

    task automatic test_write_pop();
        logic [15:0] bits;
        logic [7:0]  exp;
        int n;
        int t0;
        do_reset();
        tick_wait(130);
        write_a(8'h11);
        wait_fall(1'b0, 4, n);
        t0 = tick_no;
        write_a(8'h22); write_a(8'h33); write_a(8'h44);
        tick_wait(t0 + 159 - tick_no);
        tests++; if (bus_a.tx_level !== 4'd3) begin fails++; $display("FAIL wp_pre_level: got %0d want 3", bus_a.tx_level); end
        repeat (3) @(posedge clk);
        #1;
        bus_a.tx_write = 1'b1; bus_a.tx_data = 8'h55;
        @(posedge clk);
        #1;
        bus_a.tx_write = 1'b0;
        tests++; if (bus_a.tx_level !== 4'd3 || state_a !== START) begin fails++; $display("FAIL wp_same_clk: level=%0d state=%0d want 3 START", bus_a.tx_level, state_a); end
        t0 = tick_no;
        write_a(8'h66); write_a(8'h77); write_a(8'h88); write_a(8'h99); write_a(8'hAA);
        tests++; if (bus_a.tx_level !== 4'd8 || bus_a.tx_ovf !== 1'b0) begin fails++; $display("FAIL wp_fill: level=%0d ovf=%b want 8 0", bus_a.tx_level, bus_a.tx_ovf); end
        tick_wait(t0 + 159 - tick_no);
        repeat (3) @(posedge clk);
        #1;
        bus_a.tx_write = 1'b1; bus_a.tx_data = 8'hBB;
        @(posedge clk);
        #1;
        bus_a.tx_write = 1'b0;
        tests++; if (bus_a.tx_level !== 4'd7 || bus_a.tx_ovf !== 1'b1) begin fails++; $display("FAIL wp_full_pop: level=%0d ovf=%b want 7 1", bus_a.tx_level, bus_a.tx_ovf); end
        exp_q = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
        for (int k = 0; k < 8; k++) begin
            wait_fall(1'b0, 4, n);
            tests++; if (n != 0) begin fails++; $display("FAIL wp_gap_%0d: gap %0d ticks want 0", k, n); end
            capture(1'b0, 16, 10, bits);
            exp = exp_q.pop_front();
            tests++; if (bits !== {6'b0, 1'b1, exp, 1'b0}) begin fails++; $display("FAIL wp_frame_%0d: got %h want byte %h", k, bits, exp); end
            tick_wait(8);
        end
        wait_fall(1'b0, 40, n);
        tests++; if (n != 40) begin fails++; $display("FAIL wp_dropped_sent: frame after %0d ticks want none", n); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] bits;
        int n;
        write_a(8'h00);
        wait_fall(1'b0, 4, n);
        write_a(8'h12); write_a(8'h34);
        tick_wait(72);
        tests++; if (tx_a !== 1'b0 || state_a !== DATA) begin fails++; $display("FAIL mid_bit3: tx=%b state=%0d want 0 DATA", tx_a, state_a); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (tx_a !== 1'b1) begin fails++; $display("FAIL async_tx: got %b want 1", tx_a); end
        tests++; if (bus_a.tx_level !== 4'd0 || bus_a.tx_empty !== 1'b1 || state_a !== MARK) begin fails++; $display("FAIL async_clear: level=%0d empty=%b state=%0d want 0 1 MARK", bus_a.tx_level, bus_a.tx_empty, state_a); end
        tests++; if (bus_a.tx_ovf !== 1'b0) begin fails++; $display("FAIL async_ovf: got %b want 0", bus_a.tx_ovf); end
        tick_wait(1);
        rst_n = 1'b1;
        write_a(8'h5A);
        wait_fall(1'b0, 200, n);
        tests++; if (n != 129) begin fails++; $display("FAIL remark_len: start after %0d ticks want 129", n); end
        capture(1'b0, 16, 10, bits);
        tests++; if (bits !== 16'h02B4) begin fails++; $display("FAIL frame_5a: got %h want 02b4", bits); end
        tick_wait(8);
    endtask

    task automatic test_small_build();
        logic [15:0] bits;
        int n;
        cfg_par_en = 1'b1; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
        do_reset();
        write_b(5'h1F);
        wait_fall(1'b1, 60, n);
        tests++; if (n != 33) begin fails++; $display("FAIL small_mark_len: start after %0d ticks want 33", n); end
        capture(1'b1, 4, 8, bits);
        tests++; if (bits !== 16'h00FE) begin fails++; $display("FAIL small_frame: got %h want 00fe", bits); end
        tick_wait(1);
        tests++; if (bus_b.tx_idle !== 1'b0) begin fails++; $display("FAIL small_len_31: idle=%b want 0", bus_b.tx_idle); end
        tick_wait(1);
        tests++; if (bus_b.tx_idle !== 1'b1 || tx_b !== 1'b1) begin fails++; $display("FAIL small_len_32: idle=%b tx=%b want 1 1", bus_b.tx_idle, tx_b); end
    endtask

    initial begin
        bus_a.tx_write = 1'b0; bus_a.tx_data = '0;
        bus_b.tx_write = 1'b0; bus_b.tx_data = '0;
        #2;
        test_reset();
        test_parity_stop();
        test_fifo_full();
        test_write_pop();
        test_reset_mid_frame();
        test_small_build();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
